// File: rtl/seq_shifter.sv
// Iterative multi-mode shifter: LSL/LSR/ASR/ROR, one bit position per clock.
// Accepts an operand while idle, shifts amt times, then pulses done for one cycle and holds the result.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam logic [1:0]    MODE_LSL = 2'b00;
  localparam logic [1:0]    MODE_LSR = 2'b01;
  localparam logic [1:0]    MODE_ASR = 2'b10;
  localparam logic [AW-1:0] AMT_ONE  = AW'(1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [1:0]       mode_q;
  logic [AW-1:0]    count_q, count_d;
  logic             busy_q, done_q;

  // Single-position step; ASR keeps the sign bit, so negative values round toward minus infinity.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                  input logic [1:0]       m);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    case (m)
      MODE_LSL: return {v[WIDTH-2:0], 1'b0};
      MODE_LSR: return {1'b0, v[WIDTH-1:1]};
      MODE_ASR: return sv >>> 1;
      default:  return {v[0], v[WIDTH-1:1]};
    endcase
  endfunction

  assign shreg_d = shift_step(shreg_q, mode_q);
  assign count_d = count_q - AMT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      mode_q  <= MODE_LSL;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q <= din;
            mode_q  <= mode;
            count_q <= amt;
            busy_q  <= 1'b1;
            if (amt == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          shreg_q <= shreg_d;
          count_q <= count_d;
          if (count_q == AMT_ONE) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          // start is deliberately ignored here; the next accept needs a true idle cycle
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = shreg_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: an 8-bit instance for most scenarios and a 4-bit instance for ASR cases.
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  logic       start8 = 1'b0;
  logic [1:0] mode8 = 2'b00;
  logic [2:0] amt8 = 3'd0;
  logic [7:0] din8 = 8'h00;
  logic [7:0] dout8;
  logic       busy8, done8;

  logic       start4 = 1'b0;
  logic [1:0] mode4 = 2'b00;
  logic [1:0] amt4 = 2'd0;
  logic [3:0] din4 = 4'h0;
  logic [3:0] dout4;
  logic       busy4, done4;

  typedef struct {
    logic [7:0] exp;
    int         acc;
    int         amt;
  } sb_t;

  sb_t q8[$];
  sb_t q4[$];

  seq_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .amt(amt8),
    .din(din8), .dout(dout8), .busy(busy8), .done(done8)
  );

  seq_shifter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .amt(amt4),
    .din(din4), .dout(dout4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref8(input logic [1:0] m, input int a, input logic [7:0] d);
    logic [7:0] r;
    case (m)
      2'b00:   r = d << a;
      2'b01:   r = d >> a;
      2'b10:   r = $signed(d) >>> a;
      default: r = (d >> a) | (d << (8 - a));
    endcase
    return r;
  endfunction

  // Compare each done pulse against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done8) begin
      chk("sb8_nonempty", q8.size() != 0, 1);
      if (q8.size() != 0) begin
        sb_t e;
        e = q8.pop_front();
        chk("dout8", dout8, e.exp);
        chk("lat8", cyc - e.acc, e.amt);
      end
    end
    if (done4) begin
      chk("sb4_nonempty", q4.size() != 0, 1);
      if (q4.size() != 0) begin
        sb_t e;
        e = q4.pop_front();
        chk("dout4", dout4, e.exp);
        chk("lat4", cyc - e.acc, e.amt);
      end
    end
  end

  task automatic wait_idle8();
    for (int k = 0; k < 100 && busy8; k++) @(negedge clk);
    chk("idle_wait8", busy8, 0);
  endtask

  // One 8-bit operation; poke >= 0 drives a conflicting start in that cycle of the operation.
  task automatic run8(input logic [1:0] m, input int a, input logic [7:0] d, input int poke);
    sb_t e;
    wait_idle8();
    @(negedge clk);
    start8 = 1'b1; mode8 = m; amt8 = 3'(a); din8 = d;
    @(posedge clk);
    #1;
    e.exp = ref8(m, a, d); e.acc = cyc; e.amt = a;
    q8.push_back(e);
    start8 = 1'b0;
    for (int i = 0; i <= a; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      chk("busy8_run", busy8, 1);
      chk("done8_pulse", done8, (i == a) ? 1 : 0);
      if (i == poke) begin
        start8 = 1'b1; mode8 = m + 2'd1; amt8 = 3'(a + 1); din8 = ~d;
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    chk("busy8_after", busy8, 0);
    chk("done8_after", done8, 0);
  endtask

  task automatic run4(input logic [3:0] d, input logic [3:0] exp);
    sb_t e;
    for (int k = 0; k < 100 && busy4; k++) @(negedge clk);
    chk("idle_wait4", busy4, 0);
    @(negedge clk);
    start4 = 1'b1; mode4 = 2'b10; amt4 = 2'd1; din4 = d;
    @(posedge clk);
    #1;
    e.exp = {4'h0, exp}; e.acc = cyc; e.amt = 1;
    q4.push_back(e);
    start4 = 1'b0;
    for (int i = 0; i <= 1; i++) begin
      @(negedge clk);
      chk("done4_pulse", done4, (i == 1) ? 1 : 0);
    end
    @(negedge clk);
    chk("busy4_after", busy4, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    sb_t e;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout8", dout8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_dout4", dout4, 0);
    rst_n = 1'b1;

    // 4-bit ASR by one
    run4(4'b0111, 4'b0011);
    run4(4'b1000, 4'b1100);
    run4(4'b1100, 4'b1110);
    run4(4'b0010, 4'b0001);

    // directed 8-bit cases
    run8(2'b10, 3, 8'h80, -1);
    run8(2'b01, 3, 8'h80, -1);
    run8(2'b00, 2, 8'h07, -1);
    run8(2'b11, 1, 8'h01, -1);
    run8(2'b11, 7, 8'hA5, -1);
    for (int m = 0; m < 4; m++) run8(2'(m), 0, 8'h96, -1);

    // start held high: second accept only after one idle cycle
    wait_idle8();
    @(negedge clk);
    start8 = 1'b1; mode8 = 2'b01; amt8 = 3'd0; din8 = 8'h96;
    @(posedge clk);
    #1;
    e.exp = 8'h96; e.acc = cyc; e.amt = 0;
    q8.push_back(e);
    @(negedge clk);
    chk("hold_busy_done", busy8, 1);
    chk("hold_done", done8, 1);
    @(negedge clk);
    chk("hold_gap_busy", busy8, 0);
    @(posedge clk);
    #1;
    e.exp = 8'h96; e.acc = cyc; e.amt = 0;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    chk("hold_reaccept", busy8, 1);
    chk("hold_redone", done8, 1);

    // conflicting start mid-shift and during the done cycle
    run8(2'b00, 5, 8'h3C, 2);
    run8(2'b10, 4, 8'hC3, 4);

    // asynchronous reset between edges mid-shift
    wait_idle8();
    @(negedge clk);
    start8 = 1'b1; mode8 = 2'b00; amt8 = 3'd6; din8 = 8'hFF;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout8", dout8, 0);
    chk("arst_busy8", busy8, 0);
    chk("arst_done8", done8, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_idle", busy8 | done8, 0);
    end
    run8(2'b10, 2, 8'h9A, -1);

    // random operations against the reference model
    for (int n = 0; n < 16; n++)
      run8(2'($urandom_range(0, 3)), $urandom_range(0, 7), 8'($urandom_range(0, 255)), -1);

    repeat (5) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
